sram_req_arbiter: RTL

//  Shares one downstream sram-like port between the IF instruction requester and the MEM data requester.

---
 rtl/sram_req_arbiter_pkg.sv | 17 +
 rtl/sram_req_arbiter_id_fifo.sv | 47 ++++
 rtl/sram_req_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the IF/MEM sram request arbiter.
// Source IDs, default outstanding depth and request bundle width.
package sram_req_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam int ARB_OST_DEPTH = 4;

    // wr + size + wstrb + addr + wdata
    function automatic int sram_req_len(input int aw, input int dw);
        return 1 + 2 + 4 + aw + dw;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// 1-bit source-ID FIFO recording the issuer of each accepted request.
// Pointers wrap modulo DEPTH; count is full-width occupancy.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       din,
    output logic                       head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between IF and MEM requesters.
// Responses return in acceptance order to the issuing requester.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OST_DEPTH = ARB_OST_DEPTH,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         inst_req,
    input  logic                         inst_wr,
    input  logic [1:0]                   inst_size,
    input  logic [3:0]                   inst_wstrb,
    input  logic [ADDR_W-1:0]            inst_addr,
    input  logic [DATA_W-1:0]            inst_wdata,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [DATA_W-1:0]            inst_rdata,

    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [3:0]                   data_wstrb,
    input  logic [ADDR_W-1:0]            data_addr,
    input  logic [DATA_W-1:0]            data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [DATA_W-1:0]            data_rdata,

    output logic                         arb_req,
    output logic                         arb_wr,
    output logic [1:0]                   arb_size,
    output logic [3:0]                   arb_wstrb,
    output logic [ADDR_W-1:0]            arb_addr,
    output logic [DATA_W-1:0]            arb_wdata,
    input  logic                         arb_addr_ok,
    input  logic                         arb_data_ok,
    input  logic [DATA_W-1:0]            arb_rdata,

    output logic [$clog2(OST_DEPTH):0]   ost_cnt,
    output logic                         proto_err
);

    localparam int CW      = $clog2(OST_DEPTH) + 1;
    localparam int REQ_LEN = sram_req_len(ADDR_W, DATA_W);

    logic               r_lock;
    src_e               r_lock_src;
    logic               r_proto_err;

    src_e               w_owner;
    logic               w_owner_req;
    logic               w_full;
    logic               w_arb_req;
    logic               w_accept;
    logic               w_ost_nz;
    logic               w_pop;
    logic               w_head;
    logic [CW-1:0]      w_count;
    logic [REQ_LEN-1:0] w_inst_bus;
    logic [REQ_LEN-1:0] w_data_bus;
    logic [REQ_LEN-1:0] w_arb_bus;

    assign w_inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign w_data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

    // A locked request keeps the port until accepted; otherwise MEM wins.
    always_comb begin
        w_owner     = SRC_INST;
        w_owner_req = inst_req;
        w_arb_bus   = w_inst_bus;
        if (r_lock) begin
            w_owner = r_lock_src;
        end else if (data_req) begin
            w_owner = SRC_DATA;
        end
        if (w_owner == SRC_DATA) begin
            w_owner_req = data_req;
            w_arb_bus   = w_data_bus;
        end
    end

    assign w_full    = (w_count == CW'(OST_DEPTH));
    assign w_arb_req = w_owner_req & ~w_full & ~reset;
    assign w_accept  = w_arb_req & arb_addr_ok;
    assign w_ost_nz  = (w_count != '0);
    assign w_pop     = arb_data_ok & w_ost_nz;

    assign arb_req = w_arb_req;
    assign {arb_wr, arb_size, arb_wstrb, arb_addr, arb_wdata} = w_arb_bus;

    assign inst_addr_ok = w_accept & (w_owner == SRC_INST);
    assign data_addr_ok = w_accept & (w_owner == SRC_DATA);

    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = arb_rdata;
    assign data_rdata   = arb_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock      <= 1'b0;
            r_lock_src  <= SRC_INST;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (w_arb_req) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_owner;
            end
            if (arb_data_ok & ~w_ost_nz) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (OST_DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .pop   (w_pop),
        .din   (w_owner),
        .head  (w_head),
        .count (w_count)
    );

    assign ost_cnt   = w_count;
    assign proto_err = r_proto_err;

endmodule
